// File: rtl/div_pkg.sv
// Shared definitions for the 32/16 restoring divider: widths, FSM states and
// the quotient value reported when the result cannot be represented.
package div_pkg;

    localparam int DIVIDEND_W = 32;
    localparam int DIVISOR_W  = 16;
    localparam int COUNT_W    = 4;

    localparam logic [DIVISOR_W-1:0] QUOT_SAT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract B,
// keep the difference and set the new quotient bit when it does not borrow.
module div_step
    import div_pkg::*;
(
    input  logic [DIVISOR_W:0]   r,
    input  logic [DIVISOR_W-1:0] q,
    input  logic [DIVISOR_W-1:0] b,
    output logic [DIVISOR_W:0]   r_next,
    output logic [DIVISOR_W-1:0] q_next
);

    logic [DIVISOR_W:0] r_shift;
    logic [DIVISOR_W:0] diff;
    logic               take;

    assign r_shift = {r[DIVISOR_W-1:0], q[DIVISOR_W-1]};
    assign diff    = r_shift - {1'b0, b};
    // A set r[16] would mean the true shifted remainder exceeds 2^16 > B,
    // so the subtraction must be taken whatever the 17-bit borrow says.
    assign take    = r[DIVISOR_W] | ~diff[DIVISOR_W];

    always_comb begin
        r_next = r_shift;
        q_next = {q[DIVISOR_W-2:0], 1'b0};
        if (take) begin
            r_next    = {1'b0, diff[DIVISOR_W-1:0]};
            q_next[0] = 1'b1;
        end
    end

endmodule

// File: rtl/div32by16.sv
// Sequential 32/16 unsigned restoring divider, one quotient bit per clock,
// with LOAD/Wait/Ready handshake and divide-by-zero / overflow detection.
module div32by16
    import div_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  LOAD,
    input  logic [DIVIDEND_W-1:0] A,
    input  logic [DIVISOR_W-1:0]  B,
    output logic                  Wait,
    output logic                  Ready,
    output logic [DIVISOR_W-1:0]  quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  DivZero,
    output logic                  Overflow
);

    div_state_t             state_reg, state_next;
    logic [DIVISOR_W:0]     r_reg, r_next;
    logic [DIVISOR_W-1:0]   q_reg, q_next;
    logic [DIVISOR_W-1:0]   b_reg, b_next;
    logic [COUNT_W-1:0]     cnt_reg, cnt_next;
    logic [DIVISOR_W-1:0]   quot_reg, quot_next;
    logic [DIVISOR_W-1:0]   rem_reg, rem_next;
    logic                   ready_reg, ready_next;
    logic                   divzero_reg, divzero_next;
    logic                   overflow_reg, overflow_next;

    logic [DIVISOR_W:0]     step_r;
    logic [DIVISOR_W-1:0]   step_q;
    logic [DIVISOR_W-1:0]   a_hi;
    logic [DIVISOR_W-1:0]   a_lo;

    assign a_hi = A[DIVIDEND_W-1:DIVISOR_W];
    assign a_lo = A[DIVISOR_W-1:0];

    div_step u_step (
        .r      (r_reg),
        .q      (q_reg),
        .b      (b_reg),
        .r_next (step_r),
        .q_next (step_q)
    );

    always_comb begin
        state_next    = state_reg;
        r_next        = r_reg;
        q_next        = q_reg;
        b_next        = b_reg;
        cnt_next      = cnt_reg;
        quot_next     = quot_reg;
        rem_next      = rem_reg;
        ready_next    = ready_reg;
        divzero_next  = divzero_reg;
        overflow_next = overflow_reg;

        case (state_reg)
            IDLE, DONE: begin
                if (LOAD) begin
                    ready_next    = 1'b0;
                    divzero_next  = 1'b0;
                    overflow_next = 1'b0;
                    if (B == '0) begin
                        state_next   = DONE;
                        divzero_next = 1'b1;
                        ready_next   = 1'b1;
                        quot_next    = QUOT_SAT;
                        rem_next     = a_lo;
                    end else if (a_hi >= B) begin
                        // Quotient would need more than 16 bits.
                        state_next    = DONE;
                        overflow_next = 1'b1;
                        ready_next    = 1'b1;
                        quot_next     = QUOT_SAT;
                        rem_next      = '0;
                    end else begin
                        state_next = RUN;
                        r_next     = {1'b0, a_hi};
                        q_next     = a_lo;
                        b_next     = B;
                        cnt_next   = '1;
                    end
                end
            end
            RUN: begin
                r_next   = step_r;
                q_next   = step_q;
                cnt_next = cnt_reg - COUNT_W'(1);
                if (cnt_reg == '0) begin
                    state_next = DONE;
                    quot_next  = step_q;
                    rem_next   = step_r[DIVISOR_W-1:0];
                    ready_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg    <= IDLE;
            r_reg        <= '0;
            q_reg        <= '0;
            b_reg        <= '0;
            cnt_reg      <= '0;
            quot_reg     <= '0;
            rem_reg      <= '0;
            ready_reg    <= 1'b0;
            divzero_reg  <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            r_reg        <= r_next;
            q_reg        <= q_next;
            b_reg        <= b_next;
            cnt_reg      <= cnt_next;
            quot_reg     <= quot_next;
            rem_reg      <= rem_next;
            ready_reg    <= ready_next;
            divzero_reg  <= divzero_next;
            overflow_reg <= overflow_next;
        end
    end

    assign Wait      = (state_reg == RUN);
    assign Ready     = ready_reg;
    assign quotient  = quot_reg;
    assign remainder = rem_reg;
    assign DivZero   = divzero_reg;
    assign Overflow  = overflow_reg;

endmodule

// File: tb/tb_div32by16.sv
// Directed and random checks of div32by16 against a scoreboard of expected
// results computed from operands when each operation is launched.
module tb_div32by16;

    logic        clk;
    logic        reset;
    logic        load;
    logic [31:0] a;
    logic [15:0] b;
    logic        wait_o;
    logic        ready;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_zero;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ov;
        int          lat;
    } exp_t;

    exp_t sb[$];

    div32by16 dut (
        .CLK       (clk),
        .RESET     (reset),
        .LOAD      (load),
        .A         (a),
        .B         (b),
        .Wait      (wait_o),
        .Ready     (ready),
        .quotient  (quotient),
        .remainder (remainder),
        .DivZero   (div_zero),
        .Overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Launch one operation, optionally poking a LOAD during RUN, and check
    // busy/ready timing plus the result popped from the scoreboard.
    task automatic do_op(input logic [31:0] op_a, input logic [15:0] op_b, input int poke_at);
        exp_t e;
        exp_t got;
        int   cnt;
        if (op_b == 16'd0) begin
            e.q = 16'hFFFF; e.r = op_a[15:0]; e.dz = 1'b1; e.ov = 1'b0; e.lat = 1;
        end else if (op_a[31:16] >= op_b) begin
            e.q = 16'hFFFF; e.r = 16'h0000; e.dz = 1'b0; e.ov = 1'b1; e.lat = 1;
        end else begin
            e.q = 16'(op_a / {16'd0, op_b});
            e.r = 16'(op_a % {16'd0, op_b});
            e.dz = 1'b0; e.ov = 1'b0; e.lat = 17;
        end
        sb.push_back(e);

        @(negedge clk);
        a = op_a; b = op_b; load = 1'b1;
        @(posedge clk);
        cnt = 1;
        @(negedge clk);
        load = 1'b0;
        while (ready !== 1'b1 && cnt < 40) begin
            check("busy_wait", {31'd0, wait_o}, 32'd1);
            if (cnt == poke_at) begin
                a = 32'd9; b = 16'd2; load = 1'b1;
            end else begin
                load = 1'b0;
            end
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
        load = 1'b0;

        got = sb.pop_front();
        $display("op A=%08h B=%04h -> q=%04h r=%04h dz=%0b ov=%0b lat=%0d", op_a, op_b,
                 quotient, remainder, div_zero, overflow, cnt);
        check("latency",   cnt, got.lat);
        check("ready",     {31'd0, ready}, 32'd1);
        check("wait_done", {31'd0, wait_o}, 32'd0);
        check("quotient",  {16'd0, quotient}, {16'd0, got.q});
        check("remainder", {16'd0, remainder}, {16'd0, got.r});
        check("divzero",   {31'd0, div_zero}, {31'd0, got.dz});
        check("overflow",  {31'd0, overflow}, {31'd0, got.ov});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wait"},     {31'd0, wait_o}, 32'd0);
        check({tag, "_ready"},    {31'd0, ready}, 32'd0);
        check({tag, "_quot"},     {16'd0, quotient}, 32'd0);
        check({tag, "_rem"},      {16'd0, remainder}, 32'd0);
        check({tag, "_divzero"},  {31'd0, div_zero}, 32'd0);
        check({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
    endtask

    initial begin
        int cnt;
        int bi;
        int hi;

        reset = 1'b1; load = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        // LOAD asserted with RESET must lose.
        a = 32'd100; b = 16'd7; load = 1'b1;
        @(negedge clk);
        check_all_zero("reset");
        load = 1'b0; reset = 1'b0;
        $display("reset state checked");

        do_op(32'd100, 16'd7, -1);
        do_op(32'hFFFE_FFFF, 16'hFFFF, -1);
        do_op(32'h0001_0000, 16'd2, -1);
        do_op(32'd5, 16'd0, -1);
        do_op(32'h0005_0000, 16'd5, -1);
        do_op(32'd100, 16'd7, 5);

        // Reset in the middle of an operation discards it.
        @(negedge clk);
        a = 32'd100; b = 16'd7; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (7) @(negedge clk);
        check("run_before_reset", {31'd0, wait_o}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_all_zero("mid_reset");
        $display("reset during RUN checked");
        do_op(32'd1000, 16'd10, -1);

        // LOAD held high: restart at every DONE edge, 17 cycles apart.
        @(negedge clk);
        a = 32'd1000; b = 16'd10; load = 1'b1;
        cnt = 0;
        do begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end while (ready !== 1'b1 && cnt < 40);
        check("held_latency", cnt, 17);
        check("held_quot", {16'd0, quotient}, 32'd100);
        check("held_rem",  {16'd0, remainder}, 32'd0);
        @(negedge clk);
        check("held_restart_ready", {31'd0, ready}, 32'd0);
        check("held_restart_wait",  {31'd0, wait_o}, 32'd1);
        load = 1'b0;
        cnt = 0;
        while (ready !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check("held_second_latency", cnt, 16);
        $display("held LOAD back-to-back checked");

        for (int i = 0; i < 2000; i++) begin
            bi = int'($urandom_range(1, 65535));
            hi = int'($urandom_range(0, 32'(bi - 1)));
            do_op({16'(hi), 16'($urandom)}, 16'(bi), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
